// File: rtl/main_core_host_bridge.sv
// -----------------------------------------------------------------------------
// main_core_host_bridge
//
// Purpose:
//    Host-side initiator for main_core_serialCmd. Parses a framed byte stream
//    from the host link into core commands, 64-bit input words and
//    output-word reads, and serialises the read words back to the host.
//
//    Frame header byte: [7:6] op, [5:0] n
//       op 00 CMD   : CMD_BYTES payload bytes follow, MSB byte first
//       op 01 WRITE : n+1 words follow, 8 bytes each
//       op 10 READ  : n+1 words are pulled from the core, 8 bytes emitted each
//       op 11       : reserved, header dropped, err set (sticky until rst)
//
// Handshakes:
//    Every channel uses valid/ready: a beat transfers on the rising clock edge
//    where both valid and ready are high. A valid side holds its data stable
//    until that edge. Channel pairs: rx_valid/rx_ready, tx_valid/tx_ready,
//    cmd_hasAny/cmd_consume, in_isReady/in_canReceive,
//    out_isReady/out_canReceive.
//
// Configuration:
//    HOST_BRIDGE_BYTESWAP_EN defined   : 64-bit words LSB byte first on the link.
//    HOST_BRIDGE_BYTESWAP_EN undefined : 64-bit words MSB byte first on the link.
//    CMD payload order is the same in both builds.
//
// Ports:
//    clk, rst                  clock, asynchronous active-high reset
//    rx_byte/rx_valid/rx_ready host -> bridge byte stream
//    tx_byte/tx_valid/tx_ready bridge -> host byte stream
//    cmd/cmd_hasAny/cmd_consume         command to core
//    in/in_isReady/in_canReceive        64-bit word to core
//    out/out_isReady/out_canReceive     64-bit word from core
//    busy                      FSM not idle
//    err                       sticky reserved-opcode flag
// -----------------------------------------------------------------------------
module main_core_host_bridge #(
   parameter int CMD_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       rx_byte,
   input  logic             rx_valid,
   output logic             rx_ready,
   output logic [7:0]       tx_byte,
   output logic             tx_valid,
   input  logic             tx_ready,
   output logic [CMD_W-1:0] cmd,
   output logic             cmd_hasAny,
   input  logic             cmd_consume,
   output logic [63:0]      in,
   output logic             in_isReady,
   input  logic             in_canReceive,
   input  logic [63:0]      out,
   input  logic             out_isReady,
   output logic             out_canReceive,
   output logic             busy,
   output logic             err
);

   localparam int         CMD_BYTES = (CMD_W + 7) / 8;
   localparam int         CMD_SH_W  = CMD_BYTES * 8;
   localparam logic [2:0] CMD_LAST  = 3'(CMD_BYTES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMD_COLLECT,
      S_CMD_ISSUE,
      S_WR_COLLECT,
      S_WR_PUSH,
      S_RD_PULL,
      S_RD_EMIT
   } state_t;

   state_t              state;
   state_t              state_nx;
   logic [2:0]          byte_cnt;
   logic [5:0]          word_cnt;
   logic [5:0]          n_reg;
   logic [CMD_SH_W-1:0] cmd_sh;
   logic [CMD_SH_W-1:0] cmd_sh_nx;
   logic [CMD_W-1:0]    cmd_r;
   logic [63:0]         wr_word;
   logic [63:0]         wr_word_nx;
   logic [63:0]         rd_word;
   logic [63:0]         rd_word_nx;
   logic [7:0]          rd_head;
   logic                err_r;

   logic rx_fire;
   logic tx_fire;
   logic in_fire;
   logic out_fire;
   logic last_byte;
   logic last_word;

   assign rx_fire   = rx_valid & rx_ready;
   assign tx_fire   = tx_valid & tx_ready;
   assign in_fire   = in_isReady;   // in_isReady is already gated by in_canReceive
   assign out_fire  = out_isReady & out_canReceive;
   assign last_byte = (byte_cnt == 3'd7);
   assign last_word = (word_cnt == n_reg);

   // Shift written as a full-width expression so a single-byte command also works.
   assign cmd_sh_nx = (cmd_sh << 8) | CMD_SH_W'(rx_byte);

`ifdef HOST_BRIDGE_BYTESWAP_EN
   assign wr_word_nx = {rx_byte, wr_word[63:8]};
   assign rd_head    = rd_word[7:0];
   assign rd_word_nx = {8'h00, rd_word[63:8]};
`else
   assign wr_word_nx = {wr_word[55:0], rx_byte};
   assign rd_head    = rd_word[63:56];
   assign rd_word_nx = {rd_word[55:0], 8'h00};
`endif

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next state and handshake outputs
   always_comb begin
      state_nx       = state;
      rx_ready       = 1'b0;
      tx_valid       = 1'b0;
      tx_byte        = 8'h00;
      cmd_hasAny     = 1'b0;
      in_isReady     = 1'b0;
      out_canReceive = 1'b0;
      case (state)
         S_IDLE: begin
            rx_ready = !rst;
            if (rx_fire) begin
               case (rx_byte[7:6])
                  2'b00:   state_nx = S_CMD_COLLECT;
                  2'b01:   state_nx = S_WR_COLLECT;
                  2'b10:   state_nx = S_RD_PULL;
                  default: state_nx = S_IDLE;
               endcase
            end
         end
         S_CMD_COLLECT: begin
            rx_ready = !rst;
            if (rx_fire && byte_cnt == CMD_LAST) state_nx = S_CMD_ISSUE;
         end
         S_CMD_ISSUE: begin
            cmd_hasAny = 1'b1;
            if (cmd_consume) state_nx = S_IDLE;
         end
         S_WR_COLLECT: begin
            rx_ready = !rst;
            if (rx_fire && last_byte) state_nx = S_WR_PUSH;
         end
         S_WR_PUSH: begin
            // Combinational gate: never offer a word the core cannot take.
            in_isReady = in_canReceive;
            if (in_canReceive) state_nx = last_word ? S_IDLE : S_WR_COLLECT;
         end
         S_RD_PULL: begin
            out_canReceive = 1'b1;
            if (out_isReady) state_nx = S_RD_EMIT;
         end
         S_RD_EMIT: begin
            tx_valid = 1'b1;
            tx_byte  = rd_head;
            if (tx_ready && last_byte) state_nx = last_word ? S_IDLE : S_RD_PULL;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Datapath: counters, frame length, word and command registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         byte_cnt <= 3'd0;
         word_cnt <= 6'd0;
         n_reg    <= 6'd0;
         cmd_sh   <= '0;
         cmd_r    <= '0;
         wr_word  <= 64'd0;
         rd_word  <= 64'd0;
         err_r    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               byte_cnt <= 3'd0;
               word_cnt <= 6'd0;
               cmd_sh   <= '0;
               wr_word  <= 64'd0;
               if (rx_fire) begin
                  n_reg <= rx_byte[5:0];
                  if (rx_byte[7:6] == 2'b11) err_r <= 1'b1;
               end
            end
            S_CMD_COLLECT: begin
               if (rx_fire) begin
                  cmd_sh <= cmd_sh_nx;
                  if (byte_cnt == CMD_LAST) begin
                     byte_cnt <= 3'd0;
                     cmd_r    <= cmd_sh_nx[CMD_W-1:0];
                  end else begin
                     byte_cnt <= byte_cnt + 3'd1;
                  end
               end
            end
            S_CMD_ISSUE: begin
               if (cmd_consume) cmd_r <= '0;
            end
            S_WR_COLLECT: begin
               if (rx_fire) begin
                  wr_word  <= wr_word_nx;
                  byte_cnt <= byte_cnt + 3'd1;   // wraps 7 -> 0 at word end
               end
            end
            S_WR_PUSH: begin
               if (in_fire) begin
                  wr_word  <= 64'd0;
                  word_cnt <= word_cnt + 6'd1;
               end
            end
            S_RD_PULL: begin
               if (out_fire) begin
                  rd_word  <= out;
                  byte_cnt <= 3'd0;
               end
            end
            S_RD_EMIT: begin
               if (tx_fire) begin
                  rd_word  <= rd_word_nx;
                  byte_cnt <= byte_cnt + 3'd1;
                  if (last_byte) word_cnt <= word_cnt + 6'd1;
               end
            end
            default: begin
               byte_cnt <= 3'd0;
            end
         endcase
      end
   end

   assign cmd  = cmd_r;
   assign in   = wr_word;
   assign busy = (state != S_IDLE);
   assign err  = err_r;

endmodule

// File: tb/tb_main_core_host_bridge.sv
// -----------------------------------------------------------------------------
// tb_main_core_host_bridge
//
// Directed bench for main_core_host_bridge (CMD_W = 16). Each step drives the
// host/core ports and compares outputs with hand-computed values. Words are
// checked against the link byte order selected by HOST_BRIDGE_BYTESWAP_EN.
// -----------------------------------------------------------------------------
module tb_main_core_host_bridge;

   logic        clk;
   logic        rst;
   logic [7:0]  rx_byte;
   logic        rx_valid;
   logic        rx_ready;
   logic [7:0]  tx_byte;
   logic        tx_valid;
   logic        tx_ready;
   logic [15:0] cmd;
   logic        cmd_hasAny;
   logic        cmd_consume;
   logic [63:0] in;
   logic        in_isReady;
   logic        in_canReceive;
   logic [63:0] out;
   logic        out_isReady;
   logic        out_canReceive;
   logic        busy;
   logic        err;

   int n_checks = 0;
   int n_fail   = 0;
   logic [7:0] exp_q[$];

   main_core_host_bridge #(.CMD_W(16)) dut (
      .clk            (clk),
      .rst            (rst),
      .rx_byte        (rx_byte),
      .rx_valid       (rx_valid),
      .rx_ready       (rx_ready),
      .tx_byte        (tx_byte),
      .tx_valid       (tx_valid),
      .tx_ready       (tx_ready),
      .cmd            (cmd),
      .cmd_hasAny     (cmd_hasAny),
      .cmd_consume    (cmd_consume),
      .in             (in),
      .in_isReady     (in_isReady),
      .in_canReceive  (in_canReceive),
      .out            (out),
      .out_isReady    (out_isReady),
      .out_canReceive (out_canReceive),
      .busy           (busy),
      .err            (err)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Byte k (0 = first on the link) of a 64-bit word.
   function automatic logic [7:0] wbyte(input logic [63:0] w, input int k);
`ifdef HOST_BRIDGE_BYTESWAP_EN
      return w[8*k +: 8];
`else
      return w[63-8*k -: 8];
`endif
   endfunction

   // Expected 64-bit word from eight link bytes b0 (first) .. b7.
   function automatic logic [63:0] word_of(input logic [63:0] msb_first);
`ifdef HOST_BRIDGE_BYTESWAP_EN
      logic [63:0] r;
      for (int k = 0; k < 8; k++) r[8*k +: 8] = msb_first[63-8*k -: 8];
      return r;
`else
      return msb_first;
`endif
   endfunction

   function automatic logic [63:0] rd_pattern(input int w);
      return 64'h0123456789ABCDEF ^ (64'(w) * 64'h0101010101010101);
   endfunction

   // Drivers: every task starts and ends 1 time unit after a rising edge.
   task automatic send_byte(input logic [7:0] b);
      int t;
      rx_byte  = b;
      rx_valid = 1'b1;
      t = 0;
      while (!rx_ready && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      check("rx_ready_wait", 64'(rx_ready), 64'd1);
      @(posedge clk); #1;
      rx_valid = 1'b0;
      rx_byte  = 8'h00;
   endtask

   task automatic push_word(input logic [63:0] exp_word, input string tag);
      check({tag, "_word"}, in, exp_word);
      check({tag, "_rx_ready_low"}, 64'(rx_ready), 64'd0);
      repeat (3) begin
         @(posedge clk); #1;
         check({tag, "_isready_gated"}, 64'(in_isReady), 64'd0);
      end
      in_canReceive = 1'b1;
      #1;
      check({tag, "_isready"}, 64'(in_isReady), 64'd1);
      @(posedge clk); #1;
      in_canReceive = 1'b0;
      check({tag, "_in_cleared"}, in, 64'd0);
   endtask

   initial begin
      int tx_count;
      int pulled;
      logic take;

      rst           = 1'b0;
      rx_byte       = 8'h00;
      rx_valid      = 1'b0;
      tx_ready      = 1'b0;
      cmd_consume   = 1'b0;
      in_canReceive = 1'b0;
      out           = 64'd0;
      out_isReady   = 1'b0;

      // Reset values
      #2 rst = 1'b1;
      #2;
      check("rst_rx_ready", 64'(rx_ready), 64'd0);
      check("rst_tx_valid", 64'(tx_valid), 64'd0);
      check("rst_tx_byte", 64'(tx_byte), 64'd0);
      check("rst_cmd", 64'(cmd), 64'd0);
      check("rst_cmd_hasany", 64'(cmd_hasAny), 64'd0);
      check("rst_in", in, 64'd0);
      check("rst_in_isready", 64'(in_isReady), 64'd0);
      check("rst_out_canreceive", 64'(out_canReceive), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_err", 64'(err), 64'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      check("idle_rx_ready", 64'(rx_ready), 64'd1);

      // 1: CMD frame, held until consumed
      send_byte(8'h00);
      send_byte(8'h12);
      send_byte(8'h34);
      check("cmd_latency_hasany", 64'(cmd_hasAny), 64'd1);
      check("cmd_value", 64'(cmd), 64'h1234);
      repeat (5) begin
         @(posedge clk); #1;
         check("cmd_hold_hasany", 64'(cmd_hasAny), 64'd1);
         check("cmd_hold_value", 64'(cmd), 64'h1234);
         check("cmd_hold_rx_ready", 64'(rx_ready), 64'd0);
      end
      cmd_consume = 1'b1;
      @(posedge clk); #1;
      cmd_consume = 1'b0;
      check("cmd_drop_hasany", 64'(cmd_hasAny), 64'd0);
      check("cmd_drop_value", 64'(cmd), 64'd0);
      check("cmd_drop_busy", 64'(busy), 64'd0);

      // 2: WRITE n=1, in_canReceive held low before each push
      send_byte(8'h41);
      for (int i = 1; i <= 8; i++) send_byte(8'(i));
      push_word(word_of(64'h0102030405060708), "wr0");
      check("wr0_busy", 64'(busy), 64'd1);
      for (int i = 1; i <= 8; i++) send_byte(8'(8'h10 + i));
      push_word(word_of(64'h1112131415161718), "wr1");
      check("wr_done_busy", 64'(busy), 64'd0);

      // 3: READ n=0 with a 3-cycle tx stall mid-word
      send_byte(8'h80);
      check("rd_pull_canreceive", 64'(out_canReceive), 64'd1);
      check("rd_pull_tx_valid", 64'(tx_valid), 64'd0);
      out         = 64'hA1B2C3D4E5F60718;
      out_isReady = 1'b1;
      for (int k = 0; k < 8; k++) exp_q.push_back(wbyte(out, k));
      @(posedge clk); #1;
      out_isReady = 1'b0;
      check("rd_tx_latency", 64'(tx_valid), 64'd1);
      tx_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (i == 3) begin
            tx_ready = 1'b0;
            repeat (3) begin
               @(posedge clk); #1;
               check("rd_stall_valid", 64'(tx_valid), 64'd1);
               check("rd_stall_byte", 64'(tx_byte), 64'(exp_q[0]));
            end
            tx_ready = 1'b1;
         end
         check("rd_emit_canreceive", 64'(out_canReceive), 64'd0);
         check("rd_byte_valid", 64'(tx_valid), 64'd1);
         check("rd_byte", 64'(tx_byte), 64'(exp_q.pop_front()));
         @(posedge clk); #1;
      end
      tx_ready = 1'b0;
      check("rd_done_tx_valid", 64'(tx_valid), 64'd0);
      check("rd_done_busy", 64'(busy), 64'd0);

      // 4: reserved opcode, then a CMD frame still works
      send_byte(8'hC5);
      check("rsv_err", 64'(err), 64'd1);
      check("rsv_busy", 64'(busy), 64'd0);
      check("rsv_rx_ready", 64'(rx_ready), 64'd1);
      send_byte(8'h00);
      send_byte(8'hBE);
      send_byte(8'hEF);
      check("rsv_cmd_value", 64'(cmd), 64'hBEEF);
      check("rsv_cmd_hasany", 64'(cmd_hasAny), 64'd1);
      cmd_consume = 1'b1;
      @(posedge clk); #1;
      cmd_consume = 1'b0;
      check("rsv_err_sticky", 64'(err), 64'd1);

      // 5: reset in the middle of a WRITE word
      send_byte(8'h40);
      for (int i = 0; i < 4; i++) send_byte(8'hF0 + 8'(i));
      rst = 1'b1;
      #1;
      check("midrst_in", in, 64'd0);
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_err", 64'(err), 64'd0);
      check("midrst_rx_ready", 64'(rx_ready), 64'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      send_byte(8'h40);
      for (int i = 1; i <= 8; i++) send_byte(8'(8'h20 + i));
      push_word(word_of(64'h2122232425262728), "wr_after_rst");
      check("wr_after_rst_busy", 64'(busy), 64'd0);

      // 6: READ n=63, continuous tx_ready, one word per pull
      send_byte(8'hBF);
      pulled      = 0;
      tx_count    = 0;
      out         = rd_pattern(0);
      out_isReady = 1'b1;
      tx_ready    = 1'b1;
      for (int c = 0; c < 2000; c++) begin
         @(negedge clk);
         take = out_canReceive;
         if (tx_valid) begin
            check("long_q_level", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) check("long_byte", 64'(tx_byte), 64'(exp_q.pop_front()));
            tx_count++;
         end
         @(posedge clk); #1;
         if (take) begin
            for (int k = 0; k < 8; k++) exp_q.push_back(wbyte(out, k));
            pulled++;
            out = rd_pattern(pulled);
         end
         if (!busy) break;
      end
      out_isReady = 1'b0;
      tx_ready    = 1'b0;
      check("long_tx_count", 64'(tx_count), 64'd512);
      check("long_words_pulled", 64'(pulled), 64'd64);
      check("long_busy", 64'(busy), 64'd0);
      check("long_q_empty", 64'(exp_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
